mux7_sel: RTL and testbench

//   Single-bit select multiplexer choosing among constants 0/1, a threshold flag and

---
 rtl/mux7_sel_if.sv | 22 ++
 rtl/mux7_sel.sv | 36 +++
 tb/tb_mux7_sel.sv | 108 ++++++++++
 3 files changed

// File: rtl/mux7_sel_if.sv
// Signal bundle between the comparator/register stage and the select mux.
// The master drives the operand bits and select code; the slave returns both results.
interface mux7_sel_if;
   logic       regl_b2;
   logic       regh_b2;
   logic       regl_b0;
   logic       regh_b0;
   logic       thrsh;
   logic [2:0] muxsel;
   logic       selout;
   logic       selout_q;

   modport master (
      output regl_b2, regh_b2, regl_b0, regh_b0, thrsh, muxsel,
      input  selout, selout_q
   );

   modport slave (
      input  regl_b2, regh_b2, regl_b0, regh_b0, thrsh, muxsel,
      output selout, selout_q
   );
endinterface

// File: rtl/mux7_sel.sv
// Single-bit select mux over constants, threshold flag and operand bits 0/2.
// Gives a zero-latency result and a copy registered on clk.
module mux7_sel (
   input  logic        clk,
   input  logic        rst,
   mux7_sel_if.slave   bus
);
   logic sel_d;
   logic sel_q;

   // The default arm covers the reserved code and any X/Z select, so the output is never X.
   always_comb begin
      sel_d = 1'b0;
      case (bus.muxsel)
         3'b000:  sel_d = 1'b0;
         3'b001:  sel_d = 1'b1;
         3'b010:  sel_d = bus.thrsh;
         3'b011:  sel_d = bus.regh_b0;
         3'b100:  sel_d = bus.regl_b0;
         3'b101:  sel_d = bus.regh_b2;
         3'b110:  sel_d = bus.regl_b2;
         default: sel_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q <= 1'b0;
      end else begin
         sel_q <= sel_d;
      end
   end

   assign bus.selout   = sel_d;
   assign bus.selout_q = sel_q;
endmodule

// File: tb/tb_mux7_sel.sv
// Directed and random stimulus for mux7_sel; registered results are scoreboarded.
module tb_mux7_sel;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic exp_q_fifo[$];

   mux7_sel_if bus ();

   mux7_sel dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // d = {thrsh, regh_b0, regl_b0, regh_b2, regl_b2}
   function automatic logic model(input logic [2:0] s, input logic [4:0] d);
      logic r;
      r = 1'b0;
      if (s == 3'd1) r = 1'b1;
      if (s == 3'd2) r = d[4];
      if (s == 3'd3) r = d[3];
      if (s == 3'd4) r = d[2];
      if (s == 3'd5) r = d[1];
      if (s == 3'd6) r = d[0];
      return r;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r, input logic [2:0] s, input logic [4:0] d);
      logic e;
      logic q_exp;
      @(negedge clk);
      rst         = r;
      bus.muxsel  = s;
      bus.thrsh   = d[4];
      bus.regh_b0 = d[3];
      bus.regl_b0 = d[2];
      bus.regh_b2 = d[1];
      bus.regl_b2 = d[0];
      #1;
      e = model(s, d);
      check({tag, "_comb"}, bus.selout, e);
      exp_q_fifo.push_back(r ? 1'b0 : e);
      @(posedge clk);
      #1;
      if (exp_q_fifo.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s_q scoreboard empty observed=%b expected=none", tag, bus.selout_q);
      end else begin
         q_exp = exp_q_fifo.pop_front();
         check({tag, "_q"}, bus.selout_q, q_exp);
      end
      $display("step %-10s rst=%b sel=%0d in=%b selout=%b selout_q=%b", tag, r, s, d,
               bus.selout, bus.selout_q);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.muxsel = 3'd0;
      {bus.thrsh, bus.regh_b0, bus.regl_b0, bus.regh_b2, bus.regl_b2} = 5'b0;

      step("reset",   1'b1, 3'd0, 5'b00000);
      step("c0_zero", 1'b0, 3'd0, 5'b00000);
      step("c0_ones", 1'b0, 3'd0, 5'b11111);
      step("c1_zero", 1'b0, 3'd1, 5'b00000);
      step("thr_1",   1'b0, 3'd2, 5'b10000);
      step("thr_0",   1'b0, 3'd2, 5'b01111);
      step("hb0_1",   1'b0, 3'd3, 5'b01000);
      step("hb0_0",   1'b0, 3'd3, 5'b10111);
      step("lb0_1",   1'b0, 3'd4, 5'b00100);
      step("lb0_0",   1'b0, 3'd4, 5'b11011);
      step("hb2_1",   1'b0, 3'd5, 5'b00010);
      step("hb2_0",   1'b0, 3'd5, 5'b11101);
      step("lb2_1",   1'b0, 3'd6, 5'b00001);
      step("lb2_0",   1'b0, 3'd6, 5'b11110);
      step("rsv_ones",1'b0, 3'd7, 5'b11111);
      step("c1_pre",  1'b0, 3'd1, 5'b00000);
      step("mid_rst", 1'b1, 3'd1, 5'b00000);
      step("c1_post", 1'b0, 3'd1, 5'b00000);

      for (int i = 0; i < 48; i++) begin
         step("random", ($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)));
      end

      if (exp_q_fifo.size() != 0) begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q_fifo.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
